// File: rtl/can_pkg.sv
// Shared timing, state and stuffing definitions for the CAN receive sampler.
// Modules derive their own timing from their parameters through these helpers.
package can_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } rx_state_e;

  localparam int STUFF_LIMIT = 5;

  function automatic int calc_bit_period(input int clk_mhz, input int rate_kbits);
    return clk_mhz * 1000 / rate_kbits;
  endfunction

  function automatic int calc_sample_pt(input int bit_period);
    return bit_period * 3 / 4;
  endfunction

  localparam int BIT_PERIOD = calc_bit_period(100, 1000);
  localparam int SAMPLE_PT  = calc_sample_pt(BIT_PERIOD);
  localparam int CNT_W      = $clog2(BIT_PERIOD);

endpackage

// File: rtl/can_bit_timer.sv
// Bit-period counter with hard sync on recessive-to-dominant edges; emits the
// three majority-vote tap strobes around the sample point.
module can_bit_timer
  import can_pkg::*;
#(
  parameter int PERIOD  = BIT_PERIOD,
  parameter int SAMPLE  = SAMPLE_PT,
  parameter int TMR_W   = CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic active,
  input  logic din,
  output logic tap_early,
  output logic tap_mid,
  output logic decide
);

  logic [TMR_W-1:0] cnt_q, cnt_d;
  logic             din_prev_q, din_prev_d;
  logic             fall;

  always_comb begin
    din_prev_d = din;
    fall       = active && din_prev_q && !din;
    cnt_d      = '0;
    // A falling edge restarts the bit: the edge cycle itself counts as 0.
    if (fall) begin
      cnt_d = TMR_W'(1);
    end else if (start || active) begin
      cnt_d = (cnt_q == TMR_W'(PERIOD - 1)) ? '0 : cnt_q + TMR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      din_prev_q <= 1'b1;
    end else begin
      cnt_q      <= cnt_d;
      din_prev_q <= din_prev_d;
    end
  end

  assign tap_early = active && (cnt_q == TMR_W'(SAMPLE - 1));
  assign tap_mid   = active && (cnt_q == TMR_W'(SAMPLE));
  assign decide    = active && (cnt_q == TMR_W'(SAMPLE + 1));

endmodule

// File: rtl/can_rx_sample.sv
// CAN bit sampler: majority-vote sampling, bit de-stuffing and the output strobe.
// Starts only on a rising en, so a reset with en held high waits for a new frame.
module can_rx_sample
  import can_pkg::*;
#(
  parameter int CLK_SPEED_MHZ      = 100,
  parameter int CAN_BIT_RATE_KBITS = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic din,
  output logic dout,
  output logic dvalid
);

  localparam int LP_BIT_PERIOD = calc_bit_period(CLK_SPEED_MHZ, CAN_BIT_RATE_KBITS);
  localparam int LP_SAMPLE_PT  = calc_sample_pt(LP_BIT_PERIOD);
  localparam int LP_CNT_W      = $clog2(LP_BIT_PERIOD);

  rx_state_e  state_q, state_d;
  logic       en_prev_q, en_prev_d;
  logic       tap_a_q, tap_a_d;
  logic       tap_b_q, tap_b_d;
  logic [2:0] run_cnt_q, run_cnt_d;
  logic       last_bit_q, last_bit_d;
  logic       dout_q, dout_d;
  logic       dvalid_q, dvalid_d;

  logic start, active, bit_val, is_stuff;
  logic tap_early, tap_mid, decide;

  assign start   = (state_q == ST_IDLE) && en && !en_prev_q;
  assign active  = (state_q == ST_RUN) && en;
  assign bit_val = (tap_a_q & tap_b_q) | (tap_a_q & din) | (tap_b_q & din);

  can_bit_timer #(
    .PERIOD (LP_BIT_PERIOD),
    .SAMPLE (LP_SAMPLE_PT),
    .TMR_W  (LP_CNT_W)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .active    (active),
    .din       (din),
    .tap_early (tap_early),
    .tap_mid   (tap_mid),
    .decide    (decide)
  );

  always_comb begin
    state_d    = state_q;
    en_prev_d  = en;
    tap_a_d    = tap_a_q;
    tap_b_d    = tap_b_q;
    run_cnt_d  = run_cnt_q;
    last_bit_d = last_bit_q;
    dout_d     = dout_q;
    dvalid_d   = 1'b0;
    is_stuff   = 1'b0;

    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN: begin
        if (!en) begin
          state_d    = ST_IDLE;
          run_cnt_d  = '0;
          last_bit_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (tap_early) tap_a_d = din;
    if (tap_mid)   tap_b_d = din;

    // A stuffed bit (valid or a stuff error) restarts the run with its own value.
    if (decide) begin
      is_stuff   = (run_cnt_q == 3'(STUFF_LIMIT));
      last_bit_d = bit_val;
      if (is_stuff) begin
        run_cnt_d = 3'd1;
      end else begin
        run_cnt_d = (run_cnt_q != 3'd0 && bit_val == last_bit_q) ? run_cnt_q + 3'd1 : 3'd1;
        dout_d    = bit_val;
        dvalid_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      en_prev_q  <= 1'b1;
      tap_a_q    <= 1'b1;
      tap_b_q    <= 1'b1;
      run_cnt_q  <= '0;
      last_bit_q <= 1'b0;
      dout_q     <= 1'b1;
      dvalid_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      en_prev_q  <= en_prev_d;
      tap_a_q    <= tap_a_d;
      tap_b_q    <= tap_b_d;
      run_cnt_q  <= run_cnt_d;
      last_bit_q <= last_bit_d;
      dout_q     <= dout_d;
      dvalid_q   <= dvalid_d;
    end
  end

  assign dout   = dout_q;
  assign dvalid = dvalid_q & en;

endmodule

// File: tb/tb_can_rx_sample.sv
// Directed bench for can_rx_sample at 100 MHz / 1 Mb/s: bit vectors from a
// table plus hand-written timing sequences and a stuffed frame.
module tb_can_rx_sample;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  logic din = 1'b1;
  logic dout, dvalid;

  can_rx_sample dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .din    (din),
    .dout   (dout),
    .dvalid (dvalid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   stb_cyc[$];
  logic stb_val[$];
  always @(negedge clk) begin
    if (dvalid) begin
      stb_cyc.push_back(cyc);
      stb_val.push_back(dout);
    end
  end

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] bits;
    int          nbits;
    logic [15:0] exp;
    int          nexp;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int q_cyc(input int k);
    return (k < stb_cyc.size()) ? stb_cyc[k] : -1;
  endfunction

  function automatic int q_val(input int k);
    return (k < stb_val.size()) ? int'(stb_val[k]) : -1;
  endfunction

  task automatic clear_q();
    stb_cyc.delete();
    stb_val.delete();
  endtask

  task automatic idle_gap();
    en  = 1'b0;
    din = 1'b1;
    step(5);
  endtask

  task automatic run_bits(input logic [127:0] bits, input int n, output int t0);
    t0 = cyc;
    en = 1'b1;
    for (int i = 0; i < n; i++) begin
      din = bits[i];
      step(100);
    end
    idle_gap();
  endtask

  logic [14:0] frame_pre;
  logic [63:0] frame_tail;

  function automatic logic raw_bit(input int i);
    if (i < 15) return frame_pre[14 - i];
    return frame_tail[63 - ((i - 15) % 64)];
  endfunction

  initial begin
    int t0, e, m, p, mism, nr, ns, run;
    logic [15:0] rx;
    logic [127:0] sb, rb;
    logic last, b;

    vecs[0] = '{16'h0020, 7, 16'h0000, 6};
    vecs[1] = '{16'h0035, 6, 16'h0035, 6};
    vecs[2] = '{16'h005F, 7, 16'h003F, 6};
    vecs[3] = '{16'h0040, 7, 16'h0020, 6};
    vecs[4] = '{16'h03E0, 11, 16'h01E0, 9};
    vecs[5] = '{16'h001F, 10, 16'h001F, 9};
    frame_pre  = 15'b000011000000001;
    frame_tail = 64'hF0F3_8001_FFC0_5A6D;

    rst = 1'b1; en = 1'b0; din = 1'b1;
    step(3);
    rst = 1'b0;
    step(3);
    chk("reset_dout", int'(dout), 1);
    chk("reset_dvalid", int'(dvalid), 0);

    // Dominant held from en rise: strobes 77 and 177 cycles later.
    clear_q();
    t0 = cyc; en = 1'b1; din = 1'b0;
    step(180);
    chk("t1_first_cyc", q_cyc(0) - t0, 77);
    chk("t1_first_val", q_val(0), 0);
    chk("t1_second_cyc", q_cyc(1) - t0, 177);
    idle_gap();

    for (int i = 0; i < 6; i++) begin
      clear_q();
      run_bits(128'(vecs[i].bits), vecs[i].nbits, t0);
      rx = '0;
      for (int k = 0; k < 16 && k < stb_val.size(); k++) rx[k] = stb_val[k];
      chk($sformatf("vec%0d_count", i), stb_val.size(), vecs[i].nexp);
      chk($sformatf("vec%0d_bits", i), int'(rx), int'(vecs[i].exp));
      chk($sformatf("vec%0d_first_cyc", i), q_cyc(0) - t0, 77);
    end

    // Single dominant glitch on the last tap is outvoted.
    clear_q();
    t0 = cyc; en = 1'b1; din = 1'b1;
    step(76);
    din = 1'b0;
    step(1);
    din = 1'b1;
    step(30);
    chk("glitch_count", stb_val.size(), 1);
    chk("glitch_val", q_val(0), 1);
    chk("glitch_cyc", q_cyc(0) - t0, 77);
    idle_gap();

    // Early falling edge re-synchronises the bit.
    clear_q();
    t0 = cyc; en = 1'b1; din = 1'b0;
    step(100);
    din = 1'b1;
    step(80);
    e = cyc;
    din = 1'b0;
    step(120);
    chk("sync_count", stb_val.size(), 3);
    chk("sync_bit1_val", q_val(1), 1);
    chk("sync_after_edge", q_cyc(2) - e, 77);
    idle_gap();

    // en dropped mid-bit for 100 cycles, then raised again.
    clear_q();
    t0 = cyc; en = 1'b1; din = 1'b0;
    step(50);
    en = 1'b0;
    step(100);
    chk("en_low_strobes", stb_val.size(), 0);
    m = cyc; en = 1'b1;
    step(100);
    chk("en_reraise_cyc", q_cyc(0) - m, 77);
    chk("en_reraise_val", q_val(0), 0);
    idle_gap();

    // Reset at bit counter 50 of the second bit, en held high.
    clear_q();
    t0 = cyc; en = 1'b1; din = 1'b0;
    step(150);
    chk("rst_pre_val", q_val(0), 0);
    rst = 1'b1;
    step(1);
    chk("rst_dout", int'(dout), 1);
    chk("rst_dvalid", int'(dvalid), 0);
    rst = 1'b0;
    step(200);
    chk("rst_no_restart", stb_val.size(), 1);
    en = 1'b0;
    step(3);
    p = cyc; en = 1'b1;
    step(100);
    chk("rst_rerise_cyc", q_cyc(1) - p, 77);
    idle_gap();

    // 83-bit stuffed frame built by a bit-stuffing encoder.
    sb = '0; rb = '0;
    ns = 0; nr = 0; run = 0; last = 1'b0;
    while (ns < 83) begin
      if (run == 5) begin
        sb[ns] = ~last;
        last = ~last;
        run = 1;
        ns++;
      end else begin
        b = raw_bit(nr);
        rb[nr] = b;
        nr++;
        sb[ns] = b;
        ns++;
        run = (run != 0 && b == last) ? run + 1 : 1;
        last = b;
      end
    end
    clear_q();
    run_bits(sb, 83, t0);
    chk("frame_count", stb_val.size(), nr);
    mism = 0;
    for (int k = 0; k < nr; k++) begin
      if (q_val(k) != int'(rb[k])) mism++;
    end
    chk("frame_bit_errors", mism, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
